rv_imm_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for RV32I/RV64I decode.
- Accepts one 32-bit instruction per cycle on a valid/ready handshake and produces the sign- or zero-extended XLEN-bit immediate and its format class one cycle later.
- Carries a sideband tag and flags illegal shift encodings.
- Sits between fetch buffer and register-read stage; has a one-entry skid buffer so ready_o is register-driven, and supports pipeline flush.

---
 rtl/rv_imm_pkg.sv | 34 +++
 rtl/rv_imm_dec.sv | 105 ++++++++++
 rtl/rv_imm_gen_pipe.sv | 118 +++++++++++
 tb/tb_rv_imm_gen_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_imm_pkg.sv
// Shared opcodes, immediate-format codes and result metadata for the RV32I/RV64I immediate generator.
package rv_imm_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned TYPE_W = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI     = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL     = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR    = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [TYPE_W-1:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6,
    IMM_Z    = 3'd7
  } imm_type_e;

  typedef struct packed {
    imm_type_e typ;
    logic      illegal;
  } imm_meta_t;

endpackage

// File: rtl/rv_imm_dec.sv
// Combinational immediate decode: instruction word -> XLEN immediate, format class, illegal flag.
// CSR zimm decoding is enabled with RV_IMM_CSR_ZIMM_EN.
module rv_imm_dec
  import rv_imm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_c,
  output imm_meta_t       meta_c
);

  logic [OPC_W-1:0] opcode;
  logic             is_shift;
  logic [31:0]      imm_i32;
  logic [31:0]      imm_s32;
  logic [31:0]      imm_b32;
  logic [31:0]      imm_u32;
  logic [31:0]      imm_j32;

  assign opcode   = instr[6:0];
  assign is_shift = (instr[13:12] == 2'b01);

  // Raw 32-bit forms; every format is sign-extended from bit 31 to XLEN below.
  assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
  assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u32 = {instr[31:12], 12'b0};
  assign imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm_c          = '0;
    meta_c.typ     = IMM_NONE;
    meta_c.illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm_c      = XLEN'($signed(imm_i32));
        meta_c.typ = IMM_I;
      end
      OPC_OPIMM: begin
        if (is_shift) begin
          meta_c.typ = IMM_SH;
          if (XLEN == 64) begin
            imm_c = XLEN'(instr[25:20]);
          end else begin
            imm_c          = XLEN'(instr[24:20]);
            meta_c.illegal = instr[25];
          end
        end else begin
          imm_c      = XLEN'($signed(imm_i32));
          meta_c.typ = IMM_I;
        end
      end
      OPC_OPIMM32: begin
        // Word ops only exist on RV64; on RV32 the whole opcode is illegal.
        if (XLEN == 64) begin
          if (is_shift) begin
            imm_c          = XLEN'(instr[24:20]);
            meta_c.typ     = IMM_SH;
            meta_c.illegal = instr[25];
          end else begin
            imm_c      = XLEN'($signed(imm_i32));
            meta_c.typ = IMM_I;
          end
        end else begin
          meta_c.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        imm_c      = XLEN'($signed(imm_s32));
        meta_c.typ = IMM_S;
      end
      OPC_BRANCH: begin
        imm_c      = XLEN'($signed(imm_b32));
        meta_c.typ = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_c      = XLEN'($signed(imm_u32));
        meta_c.typ = IMM_U;
      end
      OPC_JAL: begin
        imm_c      = XLEN'($signed(imm_j32));
        meta_c.typ = IMM_J;
      end
`ifdef RV_IMM_CSR_ZIMM_EN
      OPC_SYSTEM: begin
        if (instr[14]) begin
          imm_c      = XLEN'(instr[19:15]);
          meta_c.typ = IMM_Z;
        end
      end
`else
      OPC_SYSTEM: begin
        imm_c      = '0;
        meta_c.typ = IMM_NONE;
      end
`endif
      default: begin
        imm_c      = '0;
        meta_c.typ = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/rv_imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle decode stage with valid/ready handshake,
// one-entry skid buffer (register-driven ready_o) and flush. Optional macro: RV_IMM_CSR_ZIMM_EN.
module rv_imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       instr_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   imm_o,
  output logic [TYPE_W-1:0] type_o,
  output logic              illegal_o,
  output logic [TAG_W-1:0]  tag_o
);

  logic [XLEN-1:0]  dec_imm;
  imm_meta_t        dec_meta;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  imm_meta_t        out_meta_q,  out_meta_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  logic             skid_full_q, skid_full_d;
  logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
  imm_meta_t        skid_meta_q, skid_meta_d;
  logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;

  logic             ready_q, ready_d;
  logic             accept;
  logic             out_free;

  rv_imm_dec #(.XLEN(XLEN)) u_dec (
    .instr  (instr_i),
    .imm_c  (dec_imm),
    .meta_c (dec_meta)
  );

  assign accept   = valid_i & ready_q;
  assign out_free = ~out_valid_q | ready_i;

  // Next-state: skid drains before new input; ready_q == ~skid_full_q so both never collide.
  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_meta_d  = out_meta_q;
    out_tag_d   = out_tag_q;
    skid_full_d = skid_full_q;
    skid_imm_d  = skid_imm_q;
    skid_meta_d = skid_meta_q;
    skid_tag_d  = skid_tag_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_free) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_imm_d   = skid_imm_q;
        out_meta_d  = skid_meta_q;
        out_tag_d   = skid_tag_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_meta_d  = dec_meta;
        out_tag_d   = tag_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_full_d = 1'b1;
      skid_imm_d  = dec_imm;
      skid_meta_d = dec_meta;
      skid_tag_d  = tag_i;
    end
    ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_meta_q  <= '{typ: IMM_NONE, illegal: 1'b0};
      out_tag_q   <= '0;
      skid_full_q <= 1'b0;
      skid_imm_q  <= '0;
      skid_meta_q <= '{typ: IMM_NONE, illegal: 1'b0};
      skid_tag_q  <= '0;
      ready_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_meta_q  <= out_meta_d;
      out_tag_q   <= out_tag_d;
      skid_full_q <= skid_full_d;
      skid_imm_q  <= skid_imm_d;
      skid_meta_q <= skid_meta_d;
      skid_tag_q  <= skid_tag_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = out_valid_q;
  assign imm_o     = out_imm_q;
  assign type_o    = out_meta_q.typ;
  assign illegal_o = out_meta_q.illegal;
  assign tag_o     = out_tag_q;

endmodule

// File: tb/tb_rv_imm_gen_pipe.sv
// Directed bench for rv_imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus;
// a tag scoreboard tracks ordering through backpressure, flush and reset.
module tb_rv_imm_gen_pipe;

  localparam int unsigned TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [31:0]      instr_i = '0;
  logic [TAG_W-1:0] tag_i = '0;

  logic             ready_o, valid_o, illegal_o;
  logic [63:0]      imm_o;
  logic [2:0]       type_o;
  logic [TAG_W-1:0] tag_o;

  logic             ready32, valid32, illegal32;
  logic [31:0]      imm32;
  logic [2:0]       type32;
  logic [TAG_W-1:0] tag32;

  int n_checks = 0;
  int n_errors = 0;
  int pops = 0;
  int pops_base;
  logic [TAG_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rv_imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i),
    .imm_o(imm_o), .type_o(type_o), .illegal_o(illegal_o), .tag_o(tag_o)
  );

  rv_imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready32),
    .instr_i(instr_i), .tag_i(tag_i), .valid_o(valid32), .ready_i(ready_i),
    .imm_o(imm32), .type_o(type32), .illegal_o(illegal32), .tag_o(tag32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: score the handshake seen before the edge, then sample 1 time unit after it.
  task automatic tick();
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        check("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("order_tag", 64'(tag_o), 64'(exp_q.pop_front()));
        pops++;
      end
      if (flush_i) exp_q.delete();
      else if (valid_i && ready_o) exp_q.push_back(tag_i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dec_check(input string nm, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                           input logic [63:0] e64, input logic [31:0] e32,
                           input logic [2:0] t64, input logic [2:0] t32,
                           input logic il64, input logic il32);
    valid_i = 1'b1;
    instr_i = ins;
    tag_i   = tg;
    tick();
    valid_i = 1'b0;
    check({nm, "_valid"},  64'(valid_o),   64'd1);
    check({nm, "_valid32"}, 64'(valid32),  64'd1);
    check({nm, "_imm64"},  imm_o,          e64);
    check({nm, "_imm32"},  64'(imm32),     64'(e32));
    check({nm, "_type64"}, 64'(type_o),    64'(t64));
    check({nm, "_type32"}, 64'(type32),    64'(t32));
    check({nm, "_ill64"},  64'(illegal_o), 64'(il64));
    check({nm, "_ill32"},  64'(illegal32), 64'(il32));
    check({nm, "_tag"},    64'(tag_o),     64'(tg));
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_valid"}, 64'(valid_o),   64'd0);
    check({nm, "_imm"},   imm_o,          64'd0);
    check({nm, "_type"},  64'(type_o),    64'd0);
    check({nm, "_ill"},   64'(illegal_o), 64'd0);
    check({nm, "_tag"},   64'(tag_o),     64'd0);
    check({nm, "_ready"}, 64'(ready_o),   64'd1);
    check({nm, "_ready32"}, 64'(ready32), 64'd1);
    check({nm, "_imm32"}, 64'(imm32),     64'd0);
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    check_reset_state("reset");

    // Decode table with downstream always ready (back-to-back, 1/cycle).
    ready_i = 1'b1;
    dec_check("addi",  32'hFFF00093, 8'd5,  64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0);
    dec_check("jal",   32'h0040006F, 8'd6,  64'd4,                32'd4,        3'd5, 3'd5, 1'b0, 1'b0);
    dec_check("lui",   32'h800000B7, 8'd7,  64'hFFFFFFFF80000000, 32'h80000000, 3'd4, 3'd4, 1'b0, 1'b0);
    dec_check("slli",  32'h03F09093, 8'd8,  64'd63,               32'd31,       3'd6, 3'd6, 1'b0, 1'b1);
    dec_check("srai",  32'h4200D093, 8'd9,  64'd32,               32'd0,        3'd6, 3'd6, 1'b0, 1'b1);
    dec_check("sw",    32'hFE20AE23, 8'd10, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
    dec_check("beq",   32'hFE000CE3, 8'd11, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, 3'd3, 3'd3, 1'b0, 1'b0);
    dec_check("jalr",  32'hFF008067, 8'd12, 64'hFFFFFFFFFFFFFFF0, 32'hFFFFFFF0, 3'd1, 3'd1, 1'b0, 1'b0);
    dec_check("addiw", 32'h0010009B, 8'd13, 64'd1,                32'd0,        3'd1, 3'd0, 1'b0, 1'b1);
    dec_check("slliw", 32'h0200109B, 8'd14, 64'd0,                32'd0,        3'd6, 3'd0, 1'b1, 1'b1);
`ifdef RV_IMM_CSR_ZIMM_EN
    dec_check("csrrwi", 32'h01FFD073, 8'd15, 64'd31,              32'd31,       3'd7, 3'd7, 1'b0, 1'b0);
`else
    dec_check("csrrwi", 32'h01FFD073, 8'd15, 64'd0,               32'd0,        3'd0, 3'd0, 1'b0, 1'b0);
`endif
    dec_check("custom", 32'h0000000B, 8'd16, 64'd0,               32'd0,        3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    check("drain_valid", 64'(valid_o), 64'd0);
    check("drain_queue", 64'(exp_q.size()), 64'd0);

    // Backpressure: three back-to-back, ready_i low for three cycles.
    pops_base = pops;
    ready_i = 1'b0;
    valid_i = 1'b1;
    instr_i = 32'hFFF00093;
    tag_i = 8'd1;
    tick();
    check("bp_ready_after1", 64'(ready_o), 64'd1);
    tag_i = 8'd2;
    tick();
    check("bp_ready_drop", 64'(ready_o), 64'd0);
    check("bp_tag_hold1", 64'(tag_o), 64'd1);
    tag_i = 8'd3;
    tick();
    check("bp_valid_hold", 64'(valid_o), 64'd1);
    check("bp_tag_hold2", 64'(tag_o), 64'd1);
    check("bp_imm_hold", imm_o, 64'hFFFFFFFFFFFFFFFF);
    check("bp_ready_low", 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    tick();
    check("bp_skid_out", 64'(tag_o), 64'd2);
    check("bp_ready_back", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    check("bp_third", 64'(tag_o), 64'd3);
    tick();
    check("bp_empty", 64'(valid_o), 64'd0);
    check("bp_pops", 64'(pops - pops_base), 64'd3);
    check("bp_queue", 64'(exp_q.size()), 64'd0);

    // Flush with skid full, then normal traffic.
    ready_i = 1'b0;
    valid_i = 1'b1;
    tag_i = 8'd30;
    tick();
    tag_i = 8'd31;
    tick();
    check("fl_skid_full", 64'(ready_o), 64'd0);
    valid_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ready", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    dec_check("post_flush", 32'h0040006F, 8'd32, 64'd4, 32'd4, 3'd5, 3'd5, 1'b0, 1'b0);
    valid_i = 1'b1;
    tag_i = 8'd33;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("fl_same_cycle", 64'(valid_o), 64'd0);
    tick();
    check("fl_no_ghost", 64'(valid_o), 64'd0);

    // Reset during backpressure with input still offered.
    ready_i = 1'b0;
    valid_i = 1'b1;
    instr_i = 32'h800000B7;
    tag_i = 8'd20;
    tick();
    tag_i = 8'd21;
    tick();
    check("rst_pre_ready", 64'(ready_o), 64'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    valid_i = 1'b0;
    check_reset_state("midrst");
    tick();
    check("midrst_after", 64'(valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
